// File: rtl/ir_pkg.sv
// Shared NEC infrared definitions for the IR transmit and receive paths:
// nominal segment lengths at 50 MHz, the receiver's acceptance windows,
// carrier timing and the one-hot transmitter state encoding.
package ir_pkg;

  // Nominal NEC segment lengths in 50 MHz clock cycles
  localparam int NEC_LEAD_MARK_CYC  = 450000;  // 9 ms
  localparam int NEC_LEAD_SPACE_CYC = 225000;  // 4.5 ms
  localparam int NEC_BURST_CYC      = 28000;   // 560 us
  localparam int NEC_ZERO_SPACE_CYC = 28000;   // 560 us
  localparam int NEC_ONE_SPACE_CYC  = 84500;   // 1.69 ms
  localparam int NEC_GAP_CYC        = 500000;  // 10 ms

  // Receiver acceptance windows (roughly +/-20 % around nominal)
  localparam int NEC_LEAD_MARK_MIN  = 360000;
  localparam int NEC_LEAD_MARK_MAX  = 540000;
  localparam int NEC_LEAD_SPACE_MIN = 180000;
  localparam int NEC_LEAD_SPACE_MAX = 270000;
  localparam int NEC_BURST_MIN      = 22400;
  localparam int NEC_BURST_MAX      = 33600;
  localparam int NEC_ZERO_SPACE_MIN = 22400;
  localparam int NEC_ZERO_SPACE_MAX = 33600;
  localparam int NEC_ONE_SPACE_MIN  = 67600;
  localparam int NEC_ONE_SPACE_MAX  = 101400;

  // ~38 kHz carrier with roughly 1/3 duty
  localparam int NEC_CARRIER_DIV    = 1316;
  localparam int NEC_CARRIER_HIGH   = 439;

  // Transmitter states, one-hot like the receiver FSM
  typedef enum logic [6:0] {
    S_IDLE       = 7'b0000001,
    S_LEAD_MARK  = 7'b0000010,
    S_LEAD_SPACE = 7'b0000100,
    S_BIT_MARK   = 7'b0001000,
    S_BIT_SPACE  = 7'b0010000,
    S_STOP_MARK  = 7'b0100000,
    S_GAP        = 7'b1000000
  } ir_tx_state_e;

  // Larger of two integers, for sizing counters from timing parameters
  function automatic int ir_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ir_tx_if.sv
// Frame request channel into the IR transmitter: address and command
// qualified by a valid/ready handshake.
interface ir_tx_if;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] addr_i;
  logic [7:0] cmd_i;

  // Requester side
  modport master (
    output valid_i,
    output addr_i,
    output cmd_i,
    input  ready_o
  );

  // Transmitter side
  modport slave (
    input  valid_i,
    input  addr_i,
    input  cmd_i,
    output ready_o
  );
endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier generator for the modulated LED drive. The period counter free-runs
// 0..CARRIER_DIV-1 and is forced back to 0 whenever a mark begins, so every
// mark opens with the high part of the carrier. carrier_o is registered and
// reflects the cycle the counter is entering.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int CARRIER_DIV  = NEC_CARRIER_DIV,
  parameter int CARRIER_HIGH = NEC_CARRIER_HIGH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,  // next cycle is the first cycle of a mark
  input  logic en_i,       // next cycle is inside a mark
  output logic carrier_o
);

  localparam int CW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(CARRIER_DIV - 1);
  localparam logic [CW:0]   HIGH_CNT  = (CW + 1)'(CARRIER_HIGH);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next carrier phase: wrap at the end of the period, restart at a mark
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST_CNT)) begin
      cnt_d = '0;
    end
  end

  // Phase counter and gated carrier output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      carrier_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      carrier_o <= en_i && ({1'b0, cnt_d} < HIGH_CNT);
    end
  end

endmodule

// File: rtl/ir_tx.sv
// NEC infrared frame transmitter. A request latches {addr, ~addr, cmd, ~cmd}
// and the frame is sent MSB-first as leader mark/space, 32 pulse-distance
// bits, a stop mark and a minimum idle gap. ir_o is the demodulated envelope
// (mark = 0); ir_mod_o is the carrier-gated LED drive (1 = LED on).
module ir_tx
  import ir_pkg::*;
#(
  parameter int LEAD_MARK_CYC  = NEC_LEAD_MARK_CYC,
  parameter int LEAD_SPACE_CYC = NEC_LEAD_SPACE_CYC,
  parameter int BURST_CYC      = NEC_BURST_CYC,
  parameter int ZERO_SPACE_CYC = NEC_ZERO_SPACE_CYC,
  parameter int ONE_SPACE_CYC  = NEC_ONE_SPACE_CYC,
  parameter int GAP_CYC        = NEC_GAP_CYC,
  parameter int CARRIER_DIV    = NEC_CARRIER_DIV,
  parameter int CARRIER_HIGH   = NEC_CARRIER_HIGH
) (
  input  logic      clk_i,
  input  logic      rst_i,
  ir_tx_if.slave    req,
  output logic      ir_o,
  output logic      ir_mod_o,
  output logic      done_o
);

  // Segment counter must hold the longest segment length minus one
  localparam int MAX_SEG = ir_max(ir_max(ir_max(LEAD_MARK_CYC, LEAD_SPACE_CYC),
                                         ir_max(BURST_CYC, ZERO_SPACE_CYC)),
                                  ir_max(ONE_SPACE_CYC, GAP_CYC));
  localparam int CNT_W   = $clog2(MAX_SEG + 1);

  localparam logic [CNT_W-1:0] LEAD_MARK_LAST  = CNT_W'(LEAD_MARK_CYC - 1);
  localparam logic [CNT_W-1:0] LEAD_SPACE_LAST = CNT_W'(LEAD_SPACE_CYC - 1);
  localparam logic [CNT_W-1:0] BURST_LAST      = CNT_W'(BURST_CYC - 1);
  localparam logic [CNT_W-1:0] ZERO_LAST       = CNT_W'(ZERO_SPACE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_LAST        = CNT_W'(ONE_SPACE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST        = CNT_W'(GAP_CYC - 1);

  ir_tx_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       bit_cnt_q;
  logic [31:0]      frame_q;

  logic [CNT_W-1:0] seg_last;
  logic             seg_end;
  logic             accept;
  logic             in_mark;
  logic             enter_mark;
  logic             mark_next;

  // Last counter value of the segment the current state is timing
  always_comb begin
    seg_last = '0;
    case (state_q)
      S_LEAD_MARK:             seg_last = LEAD_MARK_LAST;
      S_LEAD_SPACE:            seg_last = LEAD_SPACE_LAST;
      S_BIT_MARK, S_STOP_MARK: seg_last = BURST_LAST;
      S_BIT_SPACE:             seg_last = frame_q[31] ? ONE_LAST : ZERO_LAST;
      S_GAP:                   seg_last = GAP_LAST;
      default:                 seg_last = '0;
    endcase
  end

  assign seg_end = (cnt_q == seg_last);
  assign accept  = req.valid_i && req.ready_o;
  assign in_mark = (state_q == S_LEAD_MARK) || (state_q == S_BIT_MARK) ||
                   (state_q == S_STOP_MARK);

  // A mark begins after an accepted request or at the end of any space that
  // is followed by a mark (leader space, every bit space).
  assign enter_mark = accept ||
                      (seg_end && ((state_q == S_LEAD_SPACE) || (state_q == S_BIT_SPACE)));
  assign mark_next  = enter_mark || (in_mark && !seg_end);

  // Frame sequencer with registered envelope, ready and done outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      ir_o        <= 1'b1;
      done_o      <= 1'b0;
      req.ready_o <= 1'b1;
    end else begin
      ir_o   <= !mark_next;
      done_o <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          cnt_q       <= '0;
          req.ready_o <= 1'b1;
          if (accept) begin
            frame_q     <= {req.addr_i, ~req.addr_i, req.cmd_i, ~req.cmd_i};
            bit_cnt_q   <= '0;
            state_q     <= S_LEAD_MARK;
            req.ready_o <= 1'b0;
          end
        end
        S_LEAD_MARK: begin
          if (seg_end) begin
            cnt_q   <= '0;
            state_q <= S_LEAD_SPACE;
          end
        end
        S_LEAD_SPACE: begin
          if (seg_end) begin
            cnt_q   <= '0;
            state_q <= S_BIT_MARK;
          end
        end
        S_BIT_MARK: begin
          if (seg_end) begin
            cnt_q   <= '0;
            state_q <= S_BIT_SPACE;
          end
        end
        S_BIT_SPACE: begin
          if (seg_end) begin
            cnt_q     <= '0;
            frame_q   <= {frame_q[30:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            state_q   <= (bit_cnt_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
          end
        end
        S_STOP_MARK: begin
          if (seg_end) begin
            cnt_q   <= '0;
            state_q <= S_GAP;
            done_o  <= 1'b1;
          end
        end
        S_GAP: begin
          if (seg_end) begin
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            req.ready_o <= 1'b1;
          end
        end
        default: begin
          cnt_q       <= '0;
          state_q     <= S_IDLE;
          req.ready_o <= 1'b1;
        end
      endcase
    end
  end

  ir_carrier_gen #(
    .CARRIER_DIV  (CARRIER_DIV),
    .CARRIER_HIGH (CARRIER_HIGH)
  ) u_carrier (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .restart_i (enter_mark),
    .en_i      (mark_next),
    .carrier_o (ir_mod_o)
  );

endmodule
